stream_fifo: RTL and testbench



---
 rtl/stream_fifo.sv | 43 ++++
 tb/tb_stream_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
// stream_fifo: elastic stb/ack FIFO with registered occupancy and almost-full flag
module stream_fifo #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 8,
  parameter int ALMOST_FULL = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           input_a,
  input  logic                       input_a_stb,
  output logic                       input_a_ack,
  output logic [WIDTH-1:0]           output_z,
  output logic                       output_z_stb,
  input  logic                       output_z_ack,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr, rd;
  logic             push, pop;
  // ack is gated by rst so nothing is accepted while the queue is being flushed
  assign input_a_ack  = !rst && (count != (AW+1)'(DEPTH));
  assign output_z_stb = count != '0;
  assign output_z     = mem[rd];
  assign almost_full  = count >= (AW+1)'(ALMOST_FULL);
  assign push         = input_a_stb && input_a_ack;
  assign pop          = output_z_stb && output_z_ack;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= input_a;
        wr      <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: scoreboard bench for stream_fifo, directed cases plus a two-stage randomised chain
module tb_stream_fifo;
  logic        clk = 0, rst = 1;
  logic [15:0] a = 0, z;
  logic        a_stb = 0, a_ack, z_stb, z_ack = 0, af;
  logic [3:0]  count;
  logic [15:0] c_a = 0, m_z, o_z;
  logic        c_stb = 0, c_ack, m_stb, m_ack, o_stb, o_ack = 0, c1_af, c2_af;
  logic [3:0]  c1_count, c2_count;
  logic [15:0] exp_q[$], cq[$];
  int checks = 0, errors = 0;
  logic [14:0] seq [2] = '{0, 0};
  always #5 clk = ~clk;

  stream_fifo dut (.clk(clk), .rst(rst), .input_a(a), .input_a_stb(a_stb), .input_a_ack(a_ack),
    .output_z(z), .output_z_stb(z_stb), .output_z_ack(z_ack), .count(count), .almost_full(af));
  stream_fifo c1 (.clk(clk), .rst(rst), .input_a(c_a), .input_a_stb(c_stb), .input_a_ack(c_ack),
    .output_z(m_z), .output_z_stb(m_stb), .output_z_ack(m_ack), .count(c1_count), .almost_full(c1_af));
  stream_fifo c2 (.clk(clk), .rst(rst), .input_a(m_z), .input_a_stb(m_stb), .input_a_ack(m_ack),
    .output_z(o_z), .output_z_stb(o_stb), .output_z_ack(o_ack), .count(c2_count), .almost_full(c2_af));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty;
    int t = 0;
    while (count != 0 && t < 50) begin
      tick;
      t++;
    end
    chk("drain_count", 32'(count), 0);
  endtask

  // monitors: transfers are judged at negedge, where stb/ack are stable before the next edge
  always @(negedge clk) if (!rst) begin
    if (z_stb && z_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got %h expected nothing", z);
      end else chk("out_data", 32'(z), 32'(exp_q.pop_front()));
    end
    if (a_stb && a_ack) exp_q.push_back(a);
  end

  always @(negedge clk) if (!rst && o_stb && o_ack) begin
    if (cq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL chain_unexpected: got %h expected nothing", o_z);
    end else chk("chain_data", 32'(o_z), 32'(cq.pop_front()));
  end

  always @(posedge clk) begin
    #1;
    o_ack = $urandom_range(0, 2) != 0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick;
    @(negedge clk);
    chk("ack_in_rst", 32'(a_ack), 0);
    tick;
    rst = 0;
    @(negedge clk);
    chk("rst_ack", 32'(a_ack), 1);
    chk("rst_stb", 32'(z_stb), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_af", 32'(af), 0);
    // single word, one-cycle latency
    a = 16'h1111;
    a_stb = 1;
    tick;
    a_stb = 0;
    @(negedge clk);
    chk("t1_stb", 32'(z_stb), 1);
    chk("t1_data", 32'(z), 32'h1111);
    chk("t1_count", 32'(count), 1);
    z_ack = 1;
    tick;
    z_ack = 0;
    wait_empty;
    // fill to full
    for (int i = 1; i <= 8; i++) begin
      a = 16'(i);
      a_stb = 1;
      tick;
      @(negedge clk);
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_af", 32'(af), 32'(i >= 6));
      chk("fill_ack", 32'(a_ack), 32'(i < 8));
    end
    a = 16'h0009;
    for (int i = 0; i < 3; i++) begin
      tick;
      @(negedge clk);
      chk("full_ack", 32'(a_ack), 0);
      chk("full_count", 32'(count), 8);
    end
    // pop from full with a write held: only the pop happens, write lands next cycle
    tick;
    z_ack = 1;
    @(negedge clk);
    chk("fullpop_ack", 32'(a_ack), 0);
    chk("fullpop_head", 32'(z), 32'h0001);
    tick;
    z_ack = 0;
    @(negedge clk);
    chk("afterpop_count", 32'(count), 7);
    chk("afterpop_ack", 32'(a_ack), 1);
    tick;
    a_stb = 0;
    @(negedge clk);
    chk("refill_count", 32'(count), 8);
    z_ack = 1;
    wait_empty;
    z_ack = 0;
    chk("q_drained", 32'(exp_q.size()), 0);
    // continuous streaming across several pointer wraps
    z_ack = 1;
    for (int i = 0; i < 20; i++) begin
      a = 16'h0100 + 16'(i);
      a_stb = 1;
      tick;
      @(negedge clk);
      chk("stream_count", 32'(count), 1);
    end
    a_stb = 0;
    tick;
    z_ack = 0;
    @(negedge clk);
    chk("stream_end_count", 32'(count), 0);
    // reset mid-transfer discards stored words
    for (int i = 0; i < 5; i++) begin
      tick;
      a = 16'h00A0 + 16'(i);
      a_stb = 1;
    end
    tick;
    a = 16'h00A5;
    z_ack = 1;
    rst = 1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_ack", 32'(a_ack), 0);
    tick;
    rst = 0;
    a_stb = 0;
    z_ack = 0;
    @(negedge clk);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_stb", 32'(z_stb), 0);
    chk("midrst_af", 32'(af), 0);
    chk("midrst_ack_rel", 32'(a_ack), 1);
    tick;
    a = 16'hBEEF;
    a_stb = 1;
    tick;
    a_stb = 0;
    @(negedge clk);
    chk("beef_data", 32'(z), 32'hBEEF);
    chk("beef_count", 32'(count), 1);
    tick;
    z_ack = 1;
    tick;
    z_ack = 0;
    wait_empty;
    // two interleaved sources through a 2-deep chain with random stalls
    for (int n = 0; n < 1000; n++) begin
      int src, t;
      logic acc;
      src = $urandom_range(0, 1);
      c_a = {src[0], seq[src]};
      seq[src]++;
      c_stb = 1;
      t = 0;
      do begin
        @(negedge clk);
        acc = c_ack;
        if (acc) cq.push_back(c_a);
        tick;
        t++;
      end while (!acc && t < 200);
      if (!acc) chk("chain_accept_timeout", 32'(acc), 1);
      c_stb = 0;
      if ($urandom_range(0, 3) == 0) tick;
    end
    for (int t = 0; t < 500 && cq.size() != 0; t++) tick;
    chk("chain_drained", 32'(cq.size()), 0);
    chk("q_final", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
